// File: rtl/rfile_write_arbiter.sv
// Purpose: round-robin arbiter sharing the register-file write port among NREQ writeback requesters, plus a per-register pending scoreboard.
// Latency: a transfer in cycle t drives WE3/A3/WD3 in cycle t+1 from registers; pend updates at the edge ending the set/clear cycle.
// Backpressure: one-hot req_ready, at most one grant per cycle; the output stage never stalls, so back-to-back writes run at full rate.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   req_valid/req_addr/req_data    NREQ packed requesters (valid/ready handshake)
//   req_ready                      one-hot grant, forced low while RST is high
//   rsv_valid/rsv_addr             reserve a destination register at issue
//   pend                           per-register outstanding-write flags
//   WE3/A3/WD3                     register-file write port
module rfile_write_arbiter #(
    parameter int addWidth     = 5,
    parameter int dataWidth    = 32,
    parameter int NREQ         = 2,
    parameter int ZERO_PROTECT = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*addWidth-1:0]  req_addr,
    input  logic [NREQ*dataWidth-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      rsv_valid,
    input  logic [addWidth-1:0]       rsv_addr,
    output logic [2**addWidth-1:0]    pend,
    output logic                      WE3,
    output logic [addWidth-1:0]       A3,
    output logic [dataWidth-1:0]      WD3
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 2**addWidth;

    logic [PW-1:0]        ptr_q, ptr_d;
    logic                 we_q, we_d;
    logic [addWidth-1:0]  a3_q, a3_d;
    logic [dataWidth-1:0] wd3_q, wd3_d;
    logic [NREG-1:0]      pend_q, pend_d;

    logic [NREQ-1:0]      grant;
    logic [PW-1:0]        win;
    logic                 found;
    logic                 transfer;
    logic [addWidth-1:0]  g_addr;
    logic [dataWidth-1:0] g_data;

    // Scan requesters starting at the pointer, wrapping mod NREQ; first valid wins.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        grant = '0;
        win   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found && !RST) begin
            grant[win] = 1'b1;
        end
    end

    assign req_ready = grant;
    assign transfer  = |grant;
    assign g_addr    = req_addr[win*addWidth +: addWidth];
    assign g_data    = req_data[win*dataWidth +: dataWidth];

    always_comb begin
        ptr_d  = ptr_q;
        we_d   = 1'b0;
        a3_d   = a3_q;
        wd3_d  = wd3_q;
        pend_d = pend_q;

        if (transfer) begin
            ptr_d = (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
            // A write to r0 is still handshaken but never reaches the register file.
            we_d  = !((ZERO_PROTECT != 0) && (g_addr == '0));
            a3_d  = g_addr;
            wd3_d = g_data;
        end

        // Clear first so that a same-cycle reservation of the same register wins.
        if (WE3) begin
            pend_d[a3_q] = 1'b0;
        end
        if (rsv_valid) begin
            pend_d[rsv_addr] = 1'b1;
        end
        if (ZERO_PROTECT != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q  <= '0;
            we_q   <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
            pend_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
            pend_q <= pend_d;
        end
    end

    // A write staged just before reset must not commit during the reset cycle.
    assign WE3  = we_q & ~RST;
    assign A3   = a3_q;
    assign WD3  = wd3_q;
    assign pend = pend_q;

endmodule

// File: tb/tb_rfile_write_arbiter.sv
// Purpose: directed bench for rfile_write_arbiter; expected writes go into a queue and a monitor checks WE3/A3/WD3.
// Latency: inputs change 1ns after posedge, outputs are sampled on negedge.
// Backpressure: grants are checked against hand-computed round-robin sequences.
module tb_rfile_write_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;

    logic            CLK = 1'b0;
    logic            RST;
    logic [NR-1:0]   req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            rsv_valid;
    logic [AW-1:0]   rsv_addr;
    logic [2**AW-1:0] pend;
    logic            WE3;
    logic [AW-1:0]   A3;
    logic [DW-1:0]   WD3;

    int total = 0;
    int bad   = 0;

    logic [AW+DW-1:0] exp_q[$];

    rfile_write_arbiter #(
        .addWidth(AW), .dataWidth(DW), .NREQ(NR), .ZERO_PROTECT(1)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .pend(pend),
        .WE3(WE3), .A3(A3), .WD3(WD3)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic set_req(input logic [1:0] v, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    // Scoreboard monitor: every visible write must match the oldest expected write.
    always @(negedge CLK) begin
        if (!RST && WE3) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got A3=%0d WD3=%0h expected no write", A3, WD3);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                chk("write_addr", 64'(A3), 64'(e[AW+DW-1:DW]));
                chk("write_data", 64'(WD3), 64'(e[DW-1:0]));
            end
        end
    end

    initial begin
        RST       = 1'b1;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        set_req(2'b11, 5'd3, 32'h1, 5'd4, 32'h2);

        // 1: reset held two cycles; ready forced low despite valid requests
        sample();
        chk("rst_ready_c0", 64'(req_ready), 64'd0);
        step();
        sample();
        chk("rst_ready_c1", 64'(req_ready), 64'd0);
        chk("rst_we3", 64'(WE3), 64'd0);
        chk("rst_a3", 64'(A3), 64'd0);
        chk("rst_wd3", 64'(WD3), 64'd0);
        chk("rst_pend", 64'(pend), 64'd0);
        step();
        RST = 1'b0;
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        sample();
        chk("idle_ready", 64'(req_ready), 64'd0);

        // 2: single write
        step();
        set_req(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
        sample();
        chk("single_ready", 64'(req_ready), 64'b01);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        step();
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        sample();
        chk("single_we_t1", 64'(WE3), 64'd1);
        step();
        sample();
        chk("single_we_t2", 64'(WE3), 64'd0);

        // Pointer is 1: a requester-1 write returns it to 0.
        step();
        set_req(2'b10, 5'd0, 32'h0, 5'd3, 32'h33);
        sample();
        chk("ptr_fix_ready", 64'(req_ready), 64'b10);
        exp_q.push_back({5'd3, 32'h33});

        // 3: contention, alternate grants
        for (int i = 0; i < 4; i++) begin
            step();
            set_req(2'b11, 5'd1, 32'hA1, 5'd2, 32'hA2);
            sample();
            chk($sformatf("contend_ready_%0d", i), 64'(req_ready), (i % 2 == 0) ? 64'b01 : 64'b10);
            if (i % 2 == 0) exp_q.push_back({5'd1, 32'hA1});
            else            exp_q.push_back({5'd2, 32'hA2});
        end

        // 4: zero protect; first move pointer to 1 so the advance is observable
        step();
        set_req(2'b01, 5'd6, 32'h66, 5'd0, 32'h0);
        sample();
        chk("zp_pre_ready", 64'(req_ready), 64'b01);
        exp_q.push_back({5'd6, 32'h66});
        step();
        set_req(2'b10, 5'd0, 32'h0, 5'd0, 32'hBAD0);
        sample();
        chk("zp_ready", 64'(req_ready), 64'b10);
        step();
        set_req(2'b11, 5'd4, 32'h44, 5'd0, 32'hBAD0);
        sample();
        chk("zp_no_we", 64'(WE3), 64'd0);
        chk("zp_next_grant", 64'(req_ready), 64'b01);
        exp_q.push_back({5'd4, 32'h44});
        step();
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd0;
        step();
        rsv_valid = 1'b0;
        sample();
        chk("zp_pend0", 64'(pend), 64'd0);

        // 5 part 1: reserve 7, then write 7 clears it
        step();
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        step();
        rsv_valid = 1'b0;
        sample();
        chk("rsv_set", 64'(pend), 64'd1 << 7);
        step();
        set_req(2'b01, 5'd7, 32'h77, 5'd0, 32'h0);
        exp_q.push_back({5'd7, 32'h77});
        step();
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        sample();
        chk("clr_we", 64'(WE3), 64'd1);
        step();
        sample();
        chk("clr_pend", 64'(pend), 64'd0);

        // 5 part 2: reserve 7 while the write to 7 is on the port; set wins
        step();
        set_req(2'b01, 5'd7, 32'h78, 5'd0, 32'h0);
        exp_q.push_back({5'd7, 32'h78});
        step();
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        sample();
        chk("setwin_we", 64'(WE3), 64'd1);
        step();
        rsv_valid = 1'b0;
        sample();
        chk("setwin_pend", 64'(pend), 64'd1 << 7);

        // 6: reset mid-operation; req0 write moves pointer to 1
        step();
        set_req(2'b01, 5'd9, 32'h99, 5'd0, 32'h0);
        sample();
        chk("midrst_ready", 64'(req_ready), 64'b01);
        step();
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        RST = 1'b1;
        sample();
        chk("midrst_no_commit", 64'(WE3), 64'd0);
        step();
        RST = 1'b0;
        sample();
        chk("midrst_we", 64'(WE3), 64'd0);
        chk("midrst_pend", 64'(pend), 64'd0);
        step();
        set_req(2'b11, 5'd10, 32'hAA, 5'd11, 32'hBB);
        sample();
        chk("midrst_ptr", 64'(req_ready), 64'b01);
        exp_q.push_back({5'd10, 32'hAA});
        step();
        set_req(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        step();
        step();
        sample();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
